// File: rtl/simpleton_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simpleton_pkg: shared state codes and default widths for the       |
// | Simpleton memory arbiter.                        Rev 1.0           |
// +--------------------------------------------------------------------+
package simpleton_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_CPU  = 2'b01,
    ARB_DBG  = 2'b10
  } arb_state_t;

  localparam int AW_DEF         = 8;
  localparam int DW_DEF         = 8;
  localparam int STARVE_MAX_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/simpleton_starve_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simpleton_starve_cnt: 4-bit saturating counter of CPU cycles spent |
// | while the debug port waits.                      Rev 1.0           |
// +--------------------------------------------------------------------+
module simpleton_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic at_max
);

  logic [3:0] cnt;

  // Clear wins over increment; the count parks at MAX until cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 4'd0;
    end else if (clear) begin
      cnt <= 4'd0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_max = (cnt == 4'(MAX));

endmodule
`default_nettype wire

// File: rtl/simpleton_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simpleton_mem_arbiter: CPU/debug memory arbiter with CPU priority, |
// | lock and bounded debug starvation.               Rev 1.0           |
// +--------------------------------------------------------------------+
module simpleton_mem_arbiter
  import simpleton_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_lock,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_valid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  arb_state_t state;
  arb_state_t next_state;
  logic       at_max;
  logic       cnt_clear;
  logic       cnt_inc;

  // The unused code 11 falls into the default arm and behaves as IDLE.
  always_comb begin
    next_state = ARB_IDLE;
    case (state)
      ARB_CPU: begin
        if (cpu_lock)                          next_state = ARB_CPU;
        else if (dbg_req && (at_max || !cpu_req)) next_state = ARB_DBG;
        else if (cpu_req)                      next_state = ARB_CPU;
        else                                   next_state = ARB_IDLE;
      end
      default: begin
        if (cpu_req)      next_state = ARB_CPU;
        else if (dbg_req) next_state = ARB_DBG;
        else              next_state = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  assign cnt_clear = !dbg_req || (next_state == ARB_DBG);
  assign cnt_inc   = (state == ARB_CPU);

  simpleton_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .at_max (at_max)
  );

  assign cpu_gnt   = (state == ARB_CPU);
  assign dbg_gnt   = (state == ARB_DBG);
  assign owner     = state;
  assign cpu_rdata = cpu_gnt ? mem_rdata : '0;

  // A dropped request must never reach the memory as a write.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state)
      ARB_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we && cpu_req;
      end
      ARB_DBG: begin
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        mem_we    = dbg_we && dbg_req;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbg_rdata <= '0;
      dbg_valid <= 1'b0;
    end else begin
      dbg_valid <= dbg_gnt && dbg_req;
      if (dbg_gnt && dbg_req && !dbg_we) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simpleton_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_simpleton_mem_arbiter: randomized and directed checks against a |
// | behavioural arbiter and memory model.            Rev 1.0           |
// +--------------------------------------------------------------------+
module tb_simpleton_mem_arbiter;

  localparam int SM = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_lock, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       cpu_gnt;
  logic [7:0] cpu_rdata;
  logic       dbg_req, dbg_we;
  logic [7:0] dbg_addr, dbg_wdata;
  logic       dbg_gnt;
  logic [7:0] dbg_rdata;
  logic       dbg_valid;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
  logic [1:0] owner;

  simpleton_mem_arbiter #(
    .AW         (8),
    .DW         (8),
    .STARVE_MAX (SM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_lock  (cpu_lock),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_rdata (dbg_rdata),
    .dbg_valid (dbg_valid),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  // Memory attached to the arbiter: ROM below 0x80 ignores writes.
  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we && mem_addr[7]) mem[mem_addr] <= mem_wdata;
  end

  // Reference model: owner 0=idle 1=cpu 2=dbg, plain integer bookkeeping.
  int         m_owner;
  int         m_wait;
  logic [7:0] m_mem [256];
  logic [7:0] m_rdata;
  logic       m_valid;
  bit         cpu_done, dbg_done;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = 0;
    m_wait   = 0;
    m_rdata  = 8'h00;
    m_valid  = 1'b0;
    cpu_done = 1'b0;
    dbg_done = 1'b0;
  endtask

  // One clock edge of the arbiter as described in words.
  task automatic model_step();
    bit cpu_xfer, dbg_xfer;
    int nxt;
    cpu_xfer = (m_owner == 1) && cpu_req;
    dbg_xfer = (m_owner == 2) && dbg_req;
    m_valid  = dbg_xfer;
    if (dbg_xfer && !dbg_we) m_rdata = m_mem[dbg_addr];
    if (cpu_xfer && cpu_we && cpu_addr >= 8'd128) m_mem[cpu_addr] = cpu_wdata;
    if (dbg_xfer && dbg_we && dbg_addr >= 8'd128) m_mem[dbg_addr] = dbg_wdata;
    if (m_owner == 1 && cpu_lock)                        nxt = 1;
    else if (m_owner == 1 && dbg_req && (m_wait == SM || !cpu_req)) nxt = 2;
    else if (cpu_req)                                    nxt = 1;
    else if (dbg_req && m_owner != 1)                    nxt = 2;
    else                                                 nxt = 0;
    if (!dbg_req || nxt == 2) m_wait = 0;
    else if (m_owner == 1)    m_wait = (m_wait + 1 > SM) ? SM : m_wait + 1;
    cpu_done = cpu_xfer;
    dbg_done = dbg_xfer;
    m_owner  = nxt;
  endtask

  task automatic compare_all();
    logic [7:0] ea, ed, er;
    logic       ew;
    ea = (m_owner == 1) ? cpu_addr  : (m_owner == 2) ? dbg_addr  : 8'h00;
    ed = (m_owner == 1) ? cpu_wdata : (m_owner == 2) ? dbg_wdata : 8'h00;
    ew = (m_owner == 1) ? (cpu_we && cpu_req) : (m_owner == 2) ? (dbg_we && dbg_req) : 1'b0;
    er = (m_owner == 1) ? m_mem[cpu_addr] : 8'h00;
    check("owner",     32'(owner),     32'(m_owner));
    check("cpu_gnt",   32'(cpu_gnt),   32'(m_owner == 1));
    check("dbg_gnt",   32'(dbg_gnt),   32'(m_owner == 2));
    check("mem_addr",  32'(mem_addr),  32'(ea));
    check("mem_wdata", 32'(mem_wdata), 32'(ed));
    check("mem_we",    32'(mem_we),    32'(ew));
    check("cpu_rdata", 32'(cpu_rdata), 32'(er));
    check("dbg_rdata", 32'(dbg_rdata), 32'(m_rdata));
    check("dbg_valid", 32'(dbg_valid), 32'(m_valid));
  endtask

  // Entered just after a falling edge with inputs already applied.
  task automatic cycle();
    #1;
    compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  function automatic logic [7:0] pick_addr();
    logic [7:0] a;
    if ($urandom_range(1) == 1) a = 8'h80 + 8'($urandom_range(3));
    else                        a = 8'($urandom_range(7));
    return a;
  endfunction

  // Requesters hold a transaction until it has been transferred.
  task automatic rand_stim();
    if ((!cpu_req && $urandom_range(2) == 0) || (cpu_req && cpu_done)) begin
      cpu_req   = (!cpu_req) || ($urandom_range(2) != 0);
      cpu_we    = 1'($urandom_range(1));
      cpu_addr  = pick_addr();
      cpu_wdata = 8'($urandom);
    end
    if ((!dbg_req && $urandom_range(2) == 0) || (dbg_req && dbg_done)) begin
      dbg_req   = (!dbg_req) || ($urandom_range(1) != 0);
      dbg_we    = 1'($urandom_range(1));
      dbg_addr  = pick_addr();
      dbg_wdata = 8'($urandom);
    end
    if ($urandom_range(7) == 0) cpu_lock = ~cpu_lock;
  endtask

  task automatic set_cpu(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wdata = d;
  endtask

  initial begin
    rst = 1'b0;
    cpu_lock = 1'b0;
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    set_dbg(1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 256; i++) begin
      mem[i]   = (i < 128) ? 8'($urandom) : 8'h00;
      m_mem[i] = mem[i];
    end
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b1;

    // Idle steering, then a CPU write of 0x2A to 0x80.
    repeat (2) cycle();
    set_cpu(1'b1, 1'b1, 8'h80, 8'h2A);
    repeat (2) cycle();
    set_cpu(1'b0, 1'b0, 8'h80, 8'h00);
    cycle();

    // Both requests from idle: CPU first, debug forced in by starvation.
    set_cpu(1'b1, 1'b0, 8'h80, 8'h00);
    set_dbg(1'b1, 1'b0, 8'h80, 8'h00);
    repeat (14) cycle();

    // Lock holds the CPU past the starvation bound.
    cpu_lock = 1'b1;
    repeat (10) cycle();
    cpu_lock = 1'b0;
    repeat (3) cycle();
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    set_dbg(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) cycle();

    // Debug write 0x55 to RAM, CPU reads it back; then a ROM write.
    set_dbg(1'b1, 1'b1, 8'h80, 8'h55);
    repeat (2) cycle();
    set_dbg(1'b0, 1'b0, 8'h80, 8'h00);
    set_cpu(1'b1, 1'b0, 8'h80, 8'h00);
    repeat (2) cycle();
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    set_dbg(1'b1, 1'b1, 8'h05, 8'hFF);
    repeat (2) cycle();
    set_dbg(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) cycle();

    for (int n = 0; n < 3000; n++) begin
      rand_stim();
      cycle();
    end

    // Reset asserted mid-cycle while the CPU is locked and writing.
    cpu_lock = 1'b1;
    set_dbg(1'b0, 1'b0, 8'h00, 8'h00);
    set_cpu(1'b1, 1'b0, 8'h81, 8'h00);
    repeat (2) cycle();
    set_cpu(1'b1, 1'b1, 8'h81, 8'h2A);
    #1;
    compare_all();
    check("rst_pre_mem_we", 32'(mem_we), 32'd1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_cpu_gnt",   32'(cpu_gnt),   32'd0);
    check("rst_dbg_gnt",   32'(dbg_gnt),   32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_dbg_rdata", 32'(dbg_rdata), 32'd0);
    check("rst_dbg_valid", 32'(dbg_valid), 32'd0);
    check("rst_owner",     32'(owner),     32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_ram_0x81", 32'(mem[8'h81]), 32'(m_mem[8'h81]));
    rst = 1'b1;
    repeat (3) cycle();
    cpu_lock = 1'b0;
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) cycle();

    for (int i = 0; i < 256; i++) begin
      check("mem_image", 32'(mem[i]), 32'(m_mem[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
